// File: rtl/pwm_pkg.sv
// Shared constants for the PWM peripheral and the SPI register block that feeds it.
// Register address map and the per-pin output select helper live here.
package pwm_pkg;

    localparam int         PWM_BITS        = 8;
    localparam logic [7:0] DUTY_FULL       = 8'hFF;
    localparam int         DEFAULT_CLK_DIV = 13;
    localparam int         NUM_PINS        = 16;

    typedef enum logic [2:0] {
        ADDR_EN_OUT_7_0  = 3'd0,
        ADDR_EN_OUT_15_8 = 3'd1,
        ADDR_EN_PWM_7_0  = 3'd2,
        ADDR_EN_PWM_15_8 = 3'd3,
        ADDR_DUTY        = 3'd4
    } reg_addr_e;

    // Pin is off unless enabled; when enabled it is either static high or the shared waveform.
    function automatic logic pin_select(input logic en_out, input logic en_pwm, input logic sig);
        return en_out & (~en_pwm | sig);
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Free-running clock divider: tick is high for one clk out of every CLK_DIV.
// Generic enough to be shared with other timers.
module pwm_prescaler #(
    parameter int CLK_DIV = 13
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/pwm_peripheral.sv
// 16-pin PWM/static output block driven by five SPI-written control registers.
// Optional PWM_SHADOW_EN: duty is latched only at the period boundary for glitch-free periods.
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int CLK_DIV  = DEFAULT_CLK_DIV,
    parameter int PWM_BITS = pwm_pkg::PWM_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          en_reg_out_7_0,
    input  logic [7:0]          en_reg_out_15_8,
    input  logic [7:0]          en_reg_pwm_7_0,
    input  logic [7:0]          en_reg_pwm_15_8,
    input  logic [7:0]          pwm_duty_cycle,
    output logic [NUM_PINS-1:0] out,
    output logic                period_start
);

    logic                tick;
    logic                wrap;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty;
    logic                pwm_sig;
    logic [NUM_PINS-1:0] en_out;
    logic [NUM_PINS-1:0] en_pwm;
    logic [NUM_PINS-1:0] out_next;

    pwm_prescaler #(
        .CLK_DIV(CLK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    assign wrap   = tick && (pwm_cnt == '1);
    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

`ifdef PWM_SHADOW_EN
    logic [PWM_BITS-1:0] duty_active;

    // Loaded on the same tick that wraps the counter, so the new duty covers a whole period.
    always_ff @(posedge clk) begin
        if (!rst_n)
            duty_active <= '0;
        else if (wrap)
            duty_active <= pwm_duty_cycle;
    end

    assign duty = duty_active;
`else
    assign duty = pwm_duty_cycle;
`endif

    always_comb begin
        out_next = '0;
        for (int i = 0; i < NUM_PINS; i++)
            out_next[i] = pin_select(en_out[i], en_pwm[i], pwm_sig);
    end

    // Full duty is forced high explicitly so the waveform never dips at pwm_cnt == 255.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_cnt      <= '0;
            pwm_sig      <= 1'b0;
            out          <= '0;
            period_start <= 1'b0;
        end else begin
            if (tick)
                pwm_cnt <= pwm_cnt + 1'b1;
            pwm_sig      <= (duty == DUTY_FULL) | (pwm_cnt < duty);
            out          <= out_next;
            period_start <= wrap;
        end
    end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed self-checking bench for pwm_peripheral (default CLK_DIV = 13, period 3328 clk).
// Samples and drives 1 ns after each rising edge.
module tb_pwm_peripheral;

    localparam int PERIOD  = 13 * 256;
    localparam int TIMEOUT = 4000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
    logic [7:0]  pwm_duty_cycle;
    logic [15:0] out;
    logic        period_start;

    int total = 0;
    int bad   = 0;
    int hi_cnt [16];

    pwm_peripheral dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en_reg_out_7_0 (en_reg_out_7_0),
        .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0 (en_reg_pwm_7_0),
        .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle (pwm_duty_cycle),
        .out            (out),
        .period_start   (period_start)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_regs(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
        en_reg_out_7_0  = eo[7:0];
        en_reg_out_15_8 = eo[15:8];
        en_reg_pwm_7_0  = ep[7:0];
        en_reg_pwm_15_8 = ep[15:8];
        pwm_duty_cycle  = d;
    endtask

    // Advances until period_start is seen; returns the number of clocks waited (-1 on timeout).
    task automatic wait_ps(output int waited);
        waited = -1;
        for (int n = 1; n <= TIMEOUT; n++) begin
            step(1);
            if (period_start === 1'b1) begin
                waited = n;
                break;
            end
        end
        if (waited < 0) begin
            total++;
            bad++;
            $display("FAIL wait_period_start: no pulse within %0d clk", TIMEOUT);
        end
    endtask

    // Sums high samples per pin over one period aligned to pwm_cnt 0..255 (out lags pwm_cnt by 2).
    task automatic measure;
        int w;
        for (int b = 0; b < 16; b++) hi_cnt[b] = 0;
        wait_ps(w);
        if (w < 0) return;
        step(2);
        for (int n = 0; n < PERIOD; n++) begin
            for (int b = 0; b < 16; b++) hi_cnt[b] += int'(out[b]);
            step(1);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        set_regs(16'hFFFF, 16'hFFFF, 8'hFF);
        step(5);
        total++;
        if (out !== 16'h0000) begin bad++; $display("FAIL reset_out: got %h want 0000", out); end
        total++;
        if (period_start !== 1'b0) begin bad++; $display("FAIL reset_ps: got %b want 0", period_start); end
        rst_n = 1'b1;
        step(2);
        total++;
        if (out !== 16'hFFFF) begin bad++; $display("FAIL release_out: got %h want ffff", out); end
    endtask

    task automatic test_static;
        set_regs(16'hA5A5, 16'h0000, 8'h00);
        step(1);
        total++;
        if (out !== 16'hA5A5) begin bad++; $display("FAIL static_a5a5: got %h want a5a5", out); end
        set_regs(16'h5A5A, 16'h0000, 8'h00);
        step(1);
        total++;
        if (out !== 16'h5A5A) begin bad++; $display("FAIL static_5a5a: got %h want 5a5a", out); end
    endtask

    task automatic test_duty_sweep;
        logic [7:0] duties [4];
        int         expect_hi [4];
        duties    = '{8'h00, 8'h40, 8'h80, 8'hFF};
        expect_hi = '{0, 64 * 13, 128 * 13, PERIOD};
        for (int k = 0; k < 4; k++) begin
            set_regs(16'hFFFF, 16'hFFFF, duties[k]);
            measure();
            total++;
            if (hi_cnt[0] !== expect_hi[k]) begin
                bad++;
                $display("FAIL duty_%h_high: got %0d want %0d", duties[k], hi_cnt[0], expect_hi[k]);
            end
        end
    endtask

    task automatic test_period;
        int w;
        wait_ps(w);
        if (w < 0) return;
        wait_ps(w);
        if (w < 0) return;
        total++;
        if (w !== PERIOD) begin bad++; $display("FAIL period_len: got %0d want %0d", w, PERIOD); end
    endtask

    task automatic test_mixed;
        int pins [6];
        int want [6];
        pins = '{0, 3, 4, 7, 8, 15};
        want = '{1664, 1664, PERIOD, PERIOD, 0, 0};
        set_regs(16'h00FF, 16'h000F, 8'h80);
        measure();
        for (int k = 0; k < 6; k++) begin
            total++;
            if (hi_cnt[pins[k]] !== want[k]) begin
                bad++;
                $display("FAIL mixed_pin%0d: got %0d want %0d", pins[k], hi_cnt[pins[k]], want[k]);
            end
        end
    endtask

    task automatic test_mid_change;
        int w;
        set_regs(16'hFFFF, 16'hFFFF, 8'h20);
        wait_ps(w);
        if (w < 0) return;
        wait_ps(w);
        if (w < 0) return;
        step(64 * 13);
        total++;
        if (out !== 16'h0000) begin bad++; $display("FAIL mid_before: got %h want 0000", out); end
        pwm_duty_cycle = 8'hC0;
        step(2);
`ifdef PWM_SHADOW_EN
        total++;
        if (out !== 16'h0000) begin bad++; $display("FAIL mid_after_shadow: got %h want 0000", out); end
`else
        total++;
        if (out !== 16'hFFFF) begin bad++; $display("FAIL mid_after: got %h want ffff", out); end
`endif
        measure();
        total++;
        if (hi_cnt[0] !== 192 * 13) begin
            bad++;
            $display("FAIL mid_next_period: got %0d want %0d", hi_cnt[0], 192 * 13);
        end
    endtask

    task automatic test_reset_mid;
        int w;
        set_regs(16'hFFFF, 16'hFFFF, 8'hC0);
        wait_ps(w);
        if (w < 0) return;
        step(8'h90 * 13);
        total++;
        if (out !== 16'hFFFF) begin bad++; $display("FAIL rstmid_before: got %h want ffff", out); end
        rst_n = 1'b0;
        step(1);
        total++;
        if (out !== 16'h0000) begin bad++; $display("FAIL rstmid_out: got %h want 0000", out); end
        total++;
        if (period_start !== 1'b0) begin bad++; $display("FAIL rstmid_ps: got %b want 0", period_start); end
        step(2);
        rst_n = 1'b1;
        wait_ps(w);
        if (w < 0) return;
        total++;
        if (w !== PERIOD) begin bad++; $display("FAIL rstmid_first_ps: got %0d want %0d", w, PERIOD); end
    endtask

    initial begin
        test_reset();
        test_static();
        test_duty_sweep();
        test_period();
        test_mixed();
        test_mid_change();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
